// File: rtl/vga_pkg.sv
// Shared VGA raster constants and pixel types, used by the timing generator
// and by the video generator that drives its rgb input.
package vga_pkg;

   localparam int CNT_W    = 10;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   typedef logic [23:0] rgb_t;

   function automatic int span_total(int active, int fp, int sync, int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_pix_div.sv
// Pixel-rate divider: one-clk pix_en per CLK_DIV clocks and a registered,
// glitch-free vga_clk whose falling edge coincides with the pix_en edge.
module pix_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   output logic pix_en,
   output logic vga_clk
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

   logic [DW-1:0] div_cnt;
   logic [DW-1:0] div_next;

   always_comb begin
      div_next = div_cnt + 1'b1;
      if (div_cnt == DIV_LAST) div_next = '0;
   end

   assign pix_en = (div_cnt == DIV_LAST);

   // vga_clk is decoded from the next count so it is a pure register output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         vga_clk <= 1'b0;
      end else begin
         div_cnt <= div_next;
         vga_clk <= (div_next >= DIV_HALF);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, sync/blank decode and a registered
// output stage that keeps colour, sync and blank aligned at the DAC pins.
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic [vga_pkg::CNT_W-1:0] x,
   output logic [vga_pkg::CNT_W-1:0] y,
   input  logic [23:0]               rgb_in,
   output logic [7:0]                r,
   output logic [7:0]                g,
   output logic [7:0]                b,
   output logic                      hsync,
   output logic                      vsync,
   output logic                      blank_n,
   output logic                      sync_n,
   output logic                      vga_clk,
   output logic                      frame_start
);
   import vga_pkg::*;

   localparam int HT = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int VT = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic             pix_en;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] vcnt;
   logic             h_wrap;
   logic             v_wrap;
   logic             hs_c;
   logic             vs_c;
   logic             act_c;
   rgb_t             rgb_q;

   pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
      .clk     (clk),
      .rst     (rst),
      .pix_en  (pix_en),
      .vga_clk (vga_clk)
   );

   assign h_wrap = (hcnt == H_LAST);
   assign v_wrap = (vcnt == V_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (pix_en) begin
         if (h_wrap) begin
            hcnt <= '0;
            vcnt <= v_wrap ? '0 : vcnt + 1'b1;
         end else begin
            hcnt <= hcnt + 1'b1;
         end
      end
   end

   assign x = hcnt;
   assign y = vcnt;

   assign hs_c  = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
   assign vs_c  = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
   assign act_c = (hcnt < H_VIS) && (vcnt < V_VIS);

   // Output stage holds the pixel the counters are leaving: one pixel of latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_q   <= '0;
         hsync   <= 1'b1;
         vsync   <= 1'b1;
         blank_n <= 1'b0;
      end else if (pix_en) begin
         rgb_q   <= act_c ? rgb_t'(rgb_in) : '0;
         hsync   <= hs_c;
         vsync   <= vs_c;
         blank_n <= act_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame_start <= 1'b0;
      else     frame_start <= pix_en && h_wrap && v_wrap;
   end

   assign r      = rgb_q[23:16];
   assign g      = rgb_q[15:8];
   assign b      = rgb_q[7:0];
   assign sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (30x17 pixels,
// 4 clk per pixel); expectations come from closed-form timing of elapsed clocks.
module tb_vga_timing_gen;

   localparam int CD = 4;
   localparam int HA = 16, HF = 4, HS = 6, HB = 4;
   localparam int VA = 10, VF = 2, VS = 2, VB = 3;
   localparam int HT = 30;
   localparam int VT = 17;
   localparam int LINE_CLK  = CD * HT;
   localparam int FRAME_CLK = CD * HT * VT;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] rgb_in;
   logic [9:0]  x, y;
   logic [7:0]  r, g, b;
   logic        hsync, vsync, blank_n, sync_n, vga_clk, frame_start;

   logic        pat_mode  = 1'b0;
   logic [23:0] rgb_const = 24'h0;
   int          checks = 0;
   int          errors = 0;
   int          tcnt;

   vga_timing_gen #(
      .CLK_DIV(CD),
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .rgb_in(rgb_in),
      .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
      .blank_n(blank_n), .sync_n(sync_n), .vga_clk(vga_clk),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Stand-in video generator: purely combinational from the pixel coordinates
   always_comb rgb_in = pat_mode ? {x[7:0], y[7:0], 8'h5A} : rgb_const;

   // Clocks elapsed since reset release
   always @(posedge clk or posedge rst) begin
      if (rst) tcnt <= 0;
      else     tcnt <= tcnt + 1;
   end

   function automatic int ex_ox(int t);
      int p = t / CD;
      return (p == 0) ? -1 : (p - 1) % HT;
   endfunction

   function automatic int ex_oy(int t);
      int p = t / CD;
      return (p == 0) ? -1 : ((p - 1) / HT) % VT;
   endfunction

   function automatic logic ex_vis(int t);
      int ox = ex_ox(t);
      int oy = ex_oy(t);
      return (ox >= 0) && (ox < HA) && (oy >= 0) && (oy < VA);
   endfunction

   function automatic logic ex_hs(int t);
      int ox = ex_ox(t);
      return !((ox >= HA + HF) && (ox <= HA + HF + HS - 1));
   endfunction

   function automatic logic ex_vs(int t);
      int oy = ex_oy(t);
      return !((oy >= VA + VF) && (oy <= VA + VF + VS - 1));
   endfunction

   function automatic logic [23:0] ex_rgb(int t, logic pat, logic [23:0] konst);
      if (!ex_vis(t)) return 24'h0;
      if (pat) return {8'(ex_ox(t)), 8'(ex_oy(t)), 8'h5A};
      return konst;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (x !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", x); end
      checks++; if (y !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", y); end
      checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", hsync); end
      checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vsync); end
      checks++; if (blank_n !== 1'b0) begin errors++; $display("FAIL reset_blank_n: got %b want 0", blank_n); end
      checks++; if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h want 000000", {r, g, b}); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
      checks++; if (vga_clk !== 1'b0) begin errors++; $display("FAIL reset_vga_clk: got %b want 0", vga_clk); end
      checks++; if (sync_n !== 1'b0) begin errors++; $display("FAIL sync_n: got %b want 0", sync_n); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (vga_clk !== 1'b1) begin errors++; $display("FAIL release_vga_clk_high: got %b want 1", vga_clk); end
      @(negedge clk);
      checks++; if (x !== 10'd0) begin errors++; $display("FAIL release_x_hold: got %0d want 0", x); end
      @(negedge clk);
      checks++; if (x !== 10'd1) begin errors++; $display("FAIL release_x_step: got %0d want 1", x); end
      checks++; if (vga_clk !== 1'b0) begin errors++; $display("FAIL release_vga_clk_fall: got %b want 0", vga_clk); end
   endtask

   task automatic test_horizontal();
      bit   found = 0;
      logic prev;
      int   n, m;
      for (int i = 0; i < 4 * LINE_CLK; i++) begin
         prev = hsync;
         @(negedge clk);
         if (prev && !hsync) begin found = 1; break; end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL hsync_fall: no falling edge within %0d clk", 4 * LINE_CLK);
         return;
      end
      checks++; if (x !== 10'(HA + HF + 1)) begin errors++; $display("FAIL hsync_fall_x: got %0d want %0d", x, HA + HF + 1); end
      n = 0;
      do begin n++; @(negedge clk); end while (!hsync && n < 1000);
      checks++; if (n != HS * CD) begin errors++; $display("FAIL hsync_width: got %0d clk want %0d", n, HS * CD); end
      m = n;
      do begin prev = hsync; @(negedge clk); m++; end while (!(prev && !hsync) && m < 1000);
      checks++; if (m != LINE_CLK) begin errors++; $display("FAIL hsync_period: got %0d clk want %0d", m, LINE_CLK); end

      found = 0;
      for (int i = 0; i < 2 * FRAME_CLK; i++) begin
         prev = blank_n;
         @(negedge clk);
         if (!prev && blank_n) begin found = 1; break; end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL blank_rise: no rising edge within %0d clk", 2 * FRAME_CLK);
         return;
      end
      checks++; if (x !== 10'd1) begin errors++; $display("FAIL blank_rise_x: got %0d want 1", x); end
      n = 0;
      do begin n++; @(negedge clk); end while (blank_n && n < 1000);
      checks++; if (n != HA * CD) begin errors++; $display("FAIL blank_width: got %0d clk want %0d", n, HA * CD); end
   endtask

   task automatic test_vertical();
      bit   found = 0;
      logic prev;
      int   n, m, fs_cnt, fs_bad;
      for (int i = 0; i < 2 * FRAME_CLK; i++) begin
         prev = vsync;
         @(negedge clk);
         if (prev && !vsync) begin found = 1; break; end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL vsync_fall: no falling edge within %0d clk", 2 * FRAME_CLK);
         return;
      end
      checks++;
      if (x !== 10'd1 || y !== 10'(VA + VF)) begin
         errors++; $display("FAIL vsync_fall_xy: got (%0d,%0d) want (1,%0d)", x, y, VA + VF);
      end
      n = 0;
      do begin n++; @(negedge clk); end while (!vsync && n < 2 * FRAME_CLK);
      checks++; if (n != VS * LINE_CLK) begin errors++; $display("FAIL vsync_width: got %0d clk want %0d", n, VS * LINE_CLK); end
      m = n; fs_cnt = 0; fs_bad = 0;
      do begin
         prev = vsync;
         @(negedge clk);
         m++;
         if (frame_start) begin
            fs_cnt++;
            if (x !== 10'd0 || y !== 10'd0) fs_bad++;
         end
      end while (!(prev && !vsync) && m < 2 * FRAME_CLK);
      checks++; if (m != FRAME_CLK) begin errors++; $display("FAIL vsync_period: got %0d clk want %0d", m, FRAME_CLK); end
      checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count: got %0d clk high per frame want 1", fs_cnt); end
      checks++; if (fs_bad != 0) begin errors++; $display("FAIL frame_start_xy: got %0d pulses away from (0,0) want 0", fs_bad); end
   endtask

   task automatic test_colour_gating();
      int e_on = 0, e_off = 0, e_blank = 0, e_edge = 0, n_on = 0;
      pat_mode  = 1'b0;
      rgb_const = 24'hFFFFFF;
      for (int i = 0; i < FRAME_CLK; i++) begin
         @(negedge clk);
         if (blank_n === 1'b1) begin
            n_on++;
            if ({r, g, b} !== 24'hFFFFFF) e_on++;
         end else if ({r, g, b} !== 24'h0) begin
            e_off++;
         end
         if (blank_n !== ex_vis(tcnt)) e_blank++;
         if (ex_ox(tcnt) == HA && ex_oy(tcnt) < VA && {r, g, b} !== 24'h0) e_edge++;
      end
      checks++; if (e_on != 0) begin errors++; $display("FAIL gate_visible: got %0d samples not FFFFFF want 0", e_on); end
      checks++; if (e_off != 0) begin errors++; $display("FAIL gate_blanked: got %0d nonzero samples want 0", e_off); end
      checks++; if (e_blank != 0) begin errors++; $display("FAIL gate_blank_n: got %0d misplaced samples want 0", e_blank); end
      checks++; if (e_edge != 0) begin errors++; $display("FAIL gate_first_porch_pixel: got %0d nonzero samples want 0", e_edge); end
      checks++; if (n_on != HA * VA * CD) begin errors++; $display("FAIL gate_visible_count: got %0d clk want %0d", n_on, HA * VA * CD); end
   endtask

   task automatic test_latency();
      int e_xy = 0, e_rgb = 0, e_hs = 0, e_vs = 0, e_bl = 0, e_vc = 0, e_fs = 0, first_t = -1;
      pat_mode = 1'b1;
      for (int i = 0; i < FRAME_CLK + LINE_CLK; i++) begin
         @(negedge clk);
         if (x !== 10'((tcnt / CD) % HT) || y !== 10'(((tcnt / CD) / HT) % VT)) e_xy++;
         if ({r, g, b} !== ex_rgb(tcnt, 1'b1, rgb_const)) begin
            e_rgb++;
            if (first_t < 0) first_t = tcnt;
         end
         if (hsync !== ex_hs(tcnt)) e_hs++;
         if (vsync !== ex_vs(tcnt)) e_vs++;
         if (blank_n !== ex_vis(tcnt)) e_bl++;
         if (vga_clk !== ((tcnt % CD) >= CD / 2)) e_vc++;
         if (frame_start !== (tcnt > 0 && tcnt % FRAME_CLK == 0)) e_fs++;
      end
      checks++; if (e_xy != 0) begin errors++; $display("FAIL lat_xy: got %0d bad samples want 0", e_xy); end
      checks++; if (e_rgb != 0) begin errors++; $display("FAIL lat_rgb: got %0d bad samples (first at clk %0d) want 0", e_rgb, first_t); end
      checks++; if (e_hs != 0) begin errors++; $display("FAIL lat_hsync: got %0d bad samples want 0", e_hs); end
      checks++; if (e_vs != 0) begin errors++; $display("FAIL lat_vsync: got %0d bad samples want 0", e_vs); end
      checks++; if (e_bl != 0) begin errors++; $display("FAIL lat_blank_n: got %0d bad samples want 0", e_bl); end
      checks++; if (e_vc != 0) begin errors++; $display("FAIL lat_vga_clk: got %0d bad samples want 0", e_vc); end
      checks++; if (e_fs != 0) begin errors++; $display("FAIL lat_frame_start: got %0d bad samples want 0", e_fs); end
      pat_mode = 1'b0;
   endtask

   task automatic test_mid_frame_reset();
      bit found = 0;
      int e_fs = 0;
      rgb_const = 24'h123456;
      for (int i = 0; i < 2 * FRAME_CLK; i++) begin
         @(negedge clk);
         if (x == 10'd10 && y == 10'd5) begin found = 1; break; end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL midrst_reach: (10,5) not seen within %0d clk", 2 * FRAME_CLK);
         return;
      end
      checks++; if (blank_n !== 1'b1) begin errors++; $display("FAIL midrst_pre_blank_n: got %b want 1", blank_n); end
      rst = 1'b1;
      #1;
      checks++; if (x !== 10'd0 || y !== 10'd0) begin errors++; $display("FAIL midrst_xy: got (%0d,%0d) want (0,0)", x, y); end
      checks++; if (blank_n !== 1'b0 || {r, g, b} !== 24'h0) begin errors++; $display("FAIL midrst_blank_rgb: got %b/%h want 0/000000", blank_n, {r, g, b}); end
      checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || vga_clk !== 1'b0) begin errors++; $display("FAIL midrst_sync_clk: got hs=%b vs=%b vc=%b want 1 1 0", hsync, vsync, vga_clk); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i < FRAME_CLK; i++) begin
         @(negedge clk);
         if (frame_start !== 1'b0) e_fs++;
      end
      checks++; if (e_fs != 0) begin errors++; $display("FAIL midrst_early_frame_start: got %0d pulses want 0", e_fs); end
      @(negedge clk);
      checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL midrst_frame_start: got %b want 1 after %0d clk", frame_start, FRAME_CLK); end
      checks++; if (x !== 10'd0 || y !== 10'd0) begin errors++; $display("FAIL midrst_frame_xy: got (%0d,%0d) want (0,0)", x, y); end
   endtask

   initial begin
      test_reset();
      test_horizontal();
      test_vertical();
      test_colour_gating();
      test_latency();
      test_mid_frame_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source and output stage for the VGA path. It divides the system clock down to a pixel-rate enable and runs the horizontal and vertical counters that supply the pixel coordinates to the video generator. It registers the generator's 24-bit colour together with the sync and blank signals, so everything reaches the DAC pins aligned. It sits between the board clock/reset and the VGA DAC, with the video generator hanging off its x/y outputs and its rgb input.

## Interface
Parameters:
- CLK_DIV, 2 — system clocks per pixel (≥2; default turns 50 MHz into a 25 MHz pixel rate)
- H_ACTIVE, 640 — visible pixels per line
- H_FP, 16 — horizontal front porch, in pixels
- H_SYNC, 96 — hsync pulse width, in pixels
- H_BP, 48 — horizontal back porch, in pixels
- V_ACTIVE, 480 — visible lines per frame
- V_FP, 10 — vertical front porch, in lines
- V_SYNC, 2 — vsync pulse width, in lines
- V_BP, 33 — vertical back porch, in lines

Ports:
- clk  in  1  system clock. One clock domain only.
- rst  in  1  asynchronous, active-high reset.
- x  out  10  current horizontal count (0..H_TOTAL-1), driven directly from the counter register.
- y  out  10  current vertical count (0..V_TOTAL-1), driven directly from the counter register.
- rgb_in  in  24  colour for (x, y) from the video generator: [23:16] red, [15:8] green, [7:0] blue.
- r, g, b  out  8 each  registered colour to the DAC.
- hsync  out  1  registered, active low.
- vsync  out  1  registered, active low.
- blank_n  out  1  registered; 1 while the output pixel is in the visible area.
- sync_n  out  1  constant 0 (no sync-on-green).
- vga_clk  out  1  pixel clock to the DAC.
- frame_start  out  1  one-clk pulse at the start of each frame.

## Operation
Derived constants:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 800.
- V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP = 525.

Divider and pixel clock:
- div_cnt counts 0..CLK_DIV-1 and wraps.
- pix_en = (div_cnt == CLK_DIV-1).
- vga_clk is a register loaded every clk with (div_cnt_next ≥ CLK_DIV/2). It must be glitch-free.

Counters (advance only when pix_en = 1):
- hcnt increments and wraps from H_TOTAL-1 to 0.
- On that wrap, vcnt increments and wraps from V_TOTAL-1 to 0.

Combinational decodes from hcnt/vcnt:
- hs_c = 0 for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
- vs_c = 0 for vcnt in [490, 491].
- act_c = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).

Output stage (updates only when pix_en = 1):
- {r, g, b} ← act_c ? rgb_in : 24'h0.
- hsync ← hs_c, vsync ← vs_c, blank_n ← act_c.

frame_start:
- Registered pulse, high for exactly one clk: the clk after the pix_en cycle in which (hcnt, vcnt) wraps from (799, 524) to (0, 0).
- No pulse is produced for the partial frame that follows reset.

Reset values (asynchronous):
- div_cnt, hcnt, vcnt = 0, so x = 0 and y = 0.
- r, g, b = 0; blank_n = 0; hsync = 1; vsync = 1; vga_clk = 0; frame_start = 0.

Reset asserted mid-line or mid-frame returns all of the above to their reset values immediately. Counting restarts at (0, 0) on the first pix_en after release.

## Timing
- x/y change on the clk edge ending a pix_en cycle and are then stable for CLK_DIV clks. The video generator is combinational and has that full window to settle.
- Output latency is one pixel period: the pin values for pixel (x, y) appear on the edge where the counters leave (x, y). Sync, blank and colour stay mutually aligned.
- Output registers change on the edge where vga_clk falls. The DAC samples on the next rising edge of vga_clk.
- With defaults:
  - line = 1600 clk
  - hsync low for 192 clk
  - frame = 840000 clk
  - vsync low for 3200 clk
- rgb_in is ignored (outputs forced to 0) outside the active area, including during the porches.

## Structure
- A shared package `vga_pkg` holds the timing localparams (H_*, V_*, H_TOTAL, V_TOTAL, sync start/end positions) and an `rgb_t` 24-bit packed typedef. The video generator uses the same package.
- One sub-module, `pix_div`: the divider producing pix_en and vga_clk.
- Counters, decodes and the output stage stay in the top level.

## Test plan
- Reset: hold rst for 5 clk → x=0, y=0, hsync=1, vsync=1, blank_n=0, rgb=0, frame_start=0. Release → x becomes 1 after 2 clk.
- Horizontal timing: measure from the first hsync fall → hsync low exactly 192 clk, period 1600 clk. blank_n high 1280 clk per visible line.
- Vertical timing: vsync low 3200 clk, period 840000 clk. frame_start pulses once per period, 1 clk wide, coincident with x=0, y=0.
- Colour gating: rgb_in = 24'hFFFFFF constant → r=g=b=8'hFF exactly while blank_n=1, and 0 otherwise (e.g. the pixel after x=639).
- Latency: rgb_in = {x[7:0], y[7:0], 8'h5A} → on pins the value for (x-1, y) appears, blank and sync aligned, with no skew between them.
- Mid-frame reset: assert rst at y=200, x=300 → outputs go to reset values immediately. After release, no frame_start until the full 840000-clk frame completes.
